hazard_detection_id: RTL and testbench
======================================

# hazard_detection_ID

- Issue-side counterpart to the EXE-stage forwarding unit: it decides when forwarding cannot supply an operand and the instruction in ID must wait.
- Keeps its own 3-entry scoreboard of in-flight producers (EXE, MEM, WB).
- Compares the ID-stage sources against the scoreboard and drives the PC / IF/ID freeze, ID/EXE bubble insertion and IF flush on a taken branch.
- Sits beside the ID stage and feeds the pipeline-register enables.

## Interface
Parameters:
- ADDR_LEN, default `REG_FILE_ADDR_LEN` (5), register-address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src1_ID  in  ADDR_LEN  first source register of the ID instruction.
- src2_ID  in  ADDR_LEN  second source register of the ID instruction.
- two_src_ID  in  1  ID instruction really reads src2. 0 for immediate forms.
- dest_ID  in  ADDR_LEN  destination register of the ID instruction.
- WB_EN_ID  in  1  ID instruction writes the register file.
- MEM_R_EN_ID  in  1  ID instruction is a load.
- br_taken  in  1  branch taken, resolved in EXE.
- pipe_hold  in  1  global freeze (memory wait).
- hazard_stall  out  1  freeze PC and IF/ID.
- bubble_EXE  out  1  zero the control fields written into ID/EXE.
- flush_IF  out  1  invalidate IF/ID.
- stall_cnt  out  2  consecutive hazard-stall cycles, saturating at 3.

## Operation
- Scoreboard entries are SB_EXE, SB_MEM and SB_WB. Each holds {valid, wb_en, mem_r, dest}.
- match(e, s) = e.valid & e.wb_en & (e.dest == s) & (s != 0).
- A source is used as follows:
  - src1 is always used.
  - src2 is used only when two_src_ID = 1.
- With FORWARDING_EN (see Configuration), raw_hazard is set by a used source matching SB_EXE while SB_EXE.mem_r = 1 (load-use).
- Without FORWARDING_EN, raw_hazard is set by a used source matching SB_EXE or SB_MEM. SB_WB is never a hazard, because the register file is write-before-read.
- Output equations:
  - hazard_stall = raw_hazard & ~br_taken.
  - bubble_EXE = raw_hazard | br_taken.
  - flush_IF = br_taken.
- Priority: br_taken beats raw_hazard. The ID instruction is flushed, so it is not stalled.
- Scoreboard update on each rising clk when pipe_hold = 0:
  - SB_WB <= SB_MEM.
  - SB_MEM <= SB_EXE.
  - SB_EXE <= {~bubble_EXE, WB_EN_ID, MEM_R_EN_ID, dest_ID}.
  - A bubble therefore enters as an invalid entry.
- When pipe_hold = 1, the scoreboard and stall_cnt hold their values. Outputs are still computed combinationally.
- stall_cnt, when not held:
  - increments (saturating at 3) when hazard_stall = 1;
  - clears otherwise.
- Stall length follows from the scoreboard draining and is not separately counted:
  - load-use with forwarding: 1 cycle;
  - no forwarding, producer in SB_EXE: 2 cycles;
  - no forwarding, producer in SB_MEM: 1 cycle.

## Timing
- hazard_stall, bubble_EXE and flush_IF are combinational from the inputs and scoreboard in the same cycle. There are no registered outputs except stall_cnt.
- Scoreboard latency: an instruction seen in ID in cycle n sits in SB_EXE in n+1, SB_MEM in n+2 and SB_WB in n+3, each step absent pipe_hold.
- Reset (rst = 0, asynchronous):
  - all entries invalid and stall_cnt = 0;
  - all outputs therefore read 0 while reset is held;
  - this applies even mid-stall.
- Release of rst is synchronous to clk. The first edge after release loads SB_EXE normally.
- br_taken while pipe_hold = 1:
  - outputs assert;
  - the scoreboard does not advance;
  - the pipeline must keep br_taken asserted until hold drops.

## Configuration
- FORWARDING_EN, defined:
  - the forwarding unit is present;
  - only load-use in SB_EXE stalls;
  - a back-to-back ALU dependency gives no stall.
- FORWARDING_EN, undefined:
  - any write-enabled producer in SB_EXE or SB_MEM matching a used source stalls;
  - a back-to-back ALU dependency stalls 2 cycles.

## Structure
- ADDR_LEN default `REG_FILE_ADDR_LEN` and FORWARDING_EN come from the shared defines.v.
- The scoreboard-entry field layout (valid, wb_en, mem_r, dest) is fixed in this block.
- One natural sub-module, sb_stage: a single scoreboard entry register with async active-low reset and hold enable, instantiated three times.
- Compare logic and priority stay in the top module.

## Test plan
1. **Load-use (FORWARDING_EN):** lw r2 followed by add r3,r2,r4 -> hazard_stall = 1 and bubble_EXE = 1 for exactly 1 cycle, stall_cnt 0→1→0, add issues the next cycle.
2. **ALU back-to-back:** add r2 followed by sub r5,r2,r1:
   - with FORWARDING_EN: no stall;
   - without: hazard_stall for 2 cycles, stall_cnt reaches 2.
3. **r0 and unused src2:**
   - lw r0 followed by add r3,r0,r4 -> no stall;
   - lw r6 followed by addi r7,r1,imm with src2_ID = 6 and two_src_ID = 0 -> no stall.
4. **Branch beats hazard:** load-use hazard coincident with br_taken = 1 -> hazard_stall = 0, bubble_EXE = 1, flush_IF = 1, SB_EXE invalid after the edge.
5. **pipe_hold:** pipe_hold = 1 for 3 cycles during a load-use stall -> scoreboard and stall_cnt frozen, stall resolves 1 cycle after hold drops.
6. **Reset mid-stall:** rst = 0 during a 2-cycle no-forwarding stall -> all outputs 0 immediately, stall_cnt = 0, no stall after release.

Source files
------------

// File: rtl/hazard_detection_id_pkg.sv
// Shared scoreboard-entry layout and helpers for hazard_detection_id.
// REG_FILE_ADDR_LEN normally arrives from the shared defines.v; a fallback keeps the block standalone.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif

package hazard_detection_id_pkg;

  typedef enum logic [1:0] {
    SB_EXE = 2'd0,
    SB_MEM = 2'd1,
    SB_WB  = 2'd2
  } sb_slot_e;

  localparam int SB_DEPTH = 3;

  // Control bits of an entry, packed ahead of dest: {valid, wb_en, mem_r}
  localparam int SB_CTRL_W    = 3;
  localparam int SB_VALID_BIT = 2;
  localparam int SB_WB_BIT    = 1;
  localparam int SB_MR_BIT    = 0;

  localparam logic [1:0] STALL_CNT_MAX = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == STALL_CNT_MAX) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/hazard_detection_id_sb_stage.sv
// One scoreboard entry: control bits reset asynchronously, destination is plain data.
// Both advance only when en is high.
module hazard_detection_id_sb_stage
  import hazard_detection_id_pkg::*;
#(
  parameter int ADDR_LEN = `REG_FILE_ADDR_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SB_CTRL_W-1:0] d_ctrl,
  input  logic [ADDR_LEN-1:0]  d_dest,
  output logic [SB_CTRL_W-1:0] ctrl,
  output logic [ADDR_LEN-1:0]  dest
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= '0;
    end else if (en) begin
      ctrl <= d_ctrl;
    end
  end

  // dest is only meaningful while valid is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (en) begin
      dest <= d_dest;
    end
  end

endmodule

// File: rtl/hazard_detection_id.sv
// ID-stage hazard detection: 3-entry producer scoreboard, stall / bubble / IF-flush generation.
// Optional feature macro: FORWARDING_EN (only load-use in EXE stalls when defined).
module hazard_detection_id
  import hazard_detection_id_pkg::*;
#(
  parameter int ADDR_LEN = `REG_FILE_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] src1_ID,
  input  logic [ADDR_LEN-1:0] src2_ID,
  input  logic                two_src_ID,
  input  logic [ADDR_LEN-1:0] dest_ID,
  input  logic                WB_EN_ID,
  input  logic                MEM_R_EN_ID,
  input  logic                br_taken,
  input  logic                pipe_hold,
  output logic                hazard_stall,
  output logic                bubble_EXE,
  output logic                flush_IF,
  output logic [1:0]          stall_cnt
);

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load still in EXE
  localparam logic [SB_DEPTH-1:0] HAZ_WIN   = 3'b001;
  localparam logic                LOAD_ONLY = 1'b1;
`else
  // Write-before-read register file makes WB safe; EXE and MEM are not
  localparam logic [SB_DEPTH-1:0] HAZ_WIN   = 3'b011;
  localparam logic                LOAD_ONLY = 1'b0;
`endif

  logic [SB_CTRL_W-1:0] sb_d_ctrl [SB_DEPTH];
  logic [ADDR_LEN-1:0]  sb_d_dest [SB_DEPTH];
  logic [SB_CTRL_W-1:0] sb_ctrl   [SB_DEPTH];
  logic [ADDR_LEN-1:0]  sb_dest   [SB_DEPTH];
  logic                 raw_hazard;
  logic                 advance;

  function automatic logic src_match(input logic [SB_CTRL_W-1:0] c,
                                     input logic [ADDR_LEN-1:0]  d,
                                     input logic [ADDR_LEN-1:0]  s);
    return c[SB_VALID_BIT] & c[SB_WB_BIT] & (d == s) & (s != '0);
  endfunction

  always_comb begin
    raw_hazard = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (HAZ_WIN[k] && (sb_ctrl[k][SB_MR_BIT] || !LOAD_ONLY) &&
          (src_match(sb_ctrl[k], sb_dest[k], src1_ID) ||
           (two_src_ID && src_match(sb_ctrl[k], sb_dest[k], src2_ID)))) begin
        raw_hazard = 1'b1;
      end
    end
  end

  // A taken branch flushes the ID instruction, so it overrides the stall
  assign hazard_stall = rst & raw_hazard & ~br_taken;
  assign bubble_EXE   = rst & (raw_hazard | br_taken);
  assign flush_IF     = rst & br_taken;
  assign advance      = ~pipe_hold;

  // ID -> EXE -> MEM -> WB; a bubble enters as an invalid entry
  always_comb begin
    sb_d_ctrl[SB_EXE] = {~bubble_EXE, WB_EN_ID, MEM_R_EN_ID};
    sb_d_dest[SB_EXE] = dest_ID;
    for (int k = 1; k < SB_DEPTH; k++) begin
      sb_d_ctrl[k] = sb_ctrl[k-1];
      sb_d_dest[k] = sb_dest[k-1];
    end
  end

  for (genvar k = 0; k < SB_DEPTH; k++) begin : g_sb
    hazard_detection_id_sb_stage #(
      .ADDR_LEN(ADDR_LEN)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .d_ctrl(sb_d_ctrl[k]),
      .d_dest(sb_d_dest[k]),
      .ctrl  (sb_ctrl[k]),
      .dest  (sb_dest[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 2'd0;
    end else if (advance) begin
      stall_cnt <= hazard_stall ? sat_inc(stall_cnt) : 2'd0;
    end
  end

endmodule

// File: tb/tb_hazard_detection_id.sv
// Self-checking bench for hazard_detection_id: directed pipeline scenarios plus randomized
// traffic checked against an in-flight instruction queue model.
module tb_hazard_detection_id;

  localparam int AW = 5;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] src1_ID, src2_ID, dest_ID;
  logic          two_src_ID, WB_EN_ID, MEM_R_EN_ID, br_taken, pipe_hold;
  logic          hazard_stall, bubble_EXE, flush_IF;
  logic [1:0]    stall_cnt;
  logic [4:0]    obs;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign obs = {hazard_stall, bubble_EXE, flush_IF, stall_cnt};

  hazard_detection_id #(.ADDR_LEN(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .src1_ID     (src1_ID),
    .src2_ID     (src2_ID),
    .two_src_ID  (two_src_ID),
    .dest_ID     (dest_ID),
    .WB_EN_ID    (WB_EN_ID),
    .MEM_R_EN_ID (MEM_R_EN_ID),
    .br_taken    (br_taken),
    .pipe_hold   (pipe_hold),
    .hazard_stall(hazard_stall),
    .bubble_EXE  (bubble_EXE),
    .flush_IF    (flush_IF),
    .stall_cnt   (stall_cnt)
  );

  // Reference: the last three issued slots, newest first, plus a stall-run counter
  typedef struct {
    bit v;
    bit wb;
    bit mr;
    int dest;
  } instr_t;

  instr_t inflight[$];
  int     m_cnt = 0;

  function automatic bit m_raw();
    int reach;
    reach = FWD ? 1 : 2;
    for (int k = 0; k < reach && k < inflight.size(); k++) begin
      if (inflight[k].v && inflight[k].wb && (FWD ? inflight[k].mr : 1'b1)) begin
        if (src1_ID != 0 && inflight[k].dest == int'(src1_ID)) return 1'b1;
        if (two_src_ID && src2_ID != 0 && inflight[k].dest == int'(src2_ID)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    instr_t n;
    bit     raw;
    if (!rst) begin
      inflight.delete();
      m_cnt = 0;
    end else if (!pipe_hold) begin
      raw    = m_raw();
      n.v    = !(raw || br_taken);
      n.wb   = WB_EN_ID;
      n.mr   = MEM_R_EN_ID;
      n.dest = int'(dest_ID);
      inflight.push_front(n);
      if (inflight.size() > 3) void'(inflight.pop_back());
      m_cnt = (raw && !br_taken) ? ((m_cnt < 3) ? m_cnt + 1 : 3) : 0;
    end
  end

  task automatic drive(input int s1, input int s2, input bit two, input int d,
                       input bit wb, input bit mr, input bit br, input bit hold);
    src1_ID     = AW'(s1);
    src2_ID     = AW'(s2);
    two_src_ID  = two;
    dest_ID     = AW'(d);
    WB_EN_ID    = wb;
    MEM_R_EN_ID = mr;
    br_taken    = br;
    pipe_hold   = hold;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(2, 3, 1, 2, 1, 1, 0, 0);
    #3;
    n_run++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", obs, 5'b00000);
    end
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    logic [4:0] exp;
    drain();
    drive(1, 0, 0, 2, 1, 1, 0, 0);  // lw r2
    #3; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL lu_lw_issue: got %b want %b", obs, 5'b00000); end
    step();
    drive(2, 4, 1, 3, 1, 0, 0, 0);  // add r3,r2,r4
    #3; n_run++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL lu_stall0: got %b want %b", obs, 5'b11000); end
    step();
    exp = FWD ? 5'b00001 : 5'b11001;
    #3; n_run++;
    if (obs !== exp) begin n_fail++; $display("FAIL lu_stall1: got %b want %b", obs, exp); end
    step();
    exp = FWD ? 5'b00000 : 5'b00010;
    #3; n_run++;
    if (obs !== exp) begin n_fail++; $display("FAIL lu_resolve: got %b want %b", obs, exp); end
    step();
  endtask

  task automatic test_alu_back_to_back();
    logic [4:0] exp;
    drain();
    drive(1, 0, 0, 2, 1, 0, 0, 0);  // add r2
    step();
    drive(2, 1, 1, 5, 1, 0, 0, 0);  // sub r5,r2,r1
    exp = FWD ? 5'b00000 : 5'b11000;
    #3; n_run++;
    if (obs !== exp) begin n_fail++; $display("FAIL alu_c0: got %b want %b", obs, exp); end
    step();
    exp = FWD ? 5'b00000 : 5'b11001;
    #3; n_run++;
    if (obs !== exp) begin n_fail++; $display("FAIL alu_c1: got %b want %b", obs, exp); end
    step();
    exp = FWD ? 5'b00000 : 5'b00010;
    #3; n_run++;
    if (obs !== exp) begin n_fail++; $display("FAIL alu_c2: got %b want %b", obs, exp); end
    step();
  endtask

  task automatic test_r0_unused_src2();
    drain();
    drive(1, 0, 0, 0, 1, 1, 0, 0);  // lw r0
    step();
    drive(0, 4, 1, 3, 1, 0, 0, 0);  // add r3,r0,r4
    #3; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL r0_src: got %b want %b", obs, 5'b00000); end
    step();
    drive(1, 0, 0, 6, 1, 1, 0, 0);  // lw r6
    step();
    drive(1, 6, 0, 7, 1, 0, 0, 0);  // addi r7,r1,imm with stale src2 = 6
    #3; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL unused_src2: got %b want %b", obs, 5'b00000); end
    step();
  endtask

  task automatic test_branch_priority();
    drain();
    drive(1, 0, 0, 2, 1, 1, 0, 0);  // lw r2
    step();
    drive(2, 0, 0, 3, 1, 1, 1, 0);  // lw r3,(r2) with branch taken
    #3; n_run++;
    if (obs !== 5'b01100) begin n_fail++; $display("FAIL br_priority: got %b want %b", obs, 5'b01100); end
    step();
    drive(3, 0, 0, 4, 1, 0, 0, 0);  // reads r3: stalls only if the flushed load got in
    #3; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL br_sb_invalid: got %b want %b", obs, 5'b00000); end
    step();
  endtask

  task automatic test_pipe_hold();
    logic [4:0] exp;
    drain();
    drive(1, 0, 0, 2, 1, 1, 0, 0);  // lw r2
    step();
    for (int i = 0; i < 3; i++) begin
      drive(2, 4, 1, 3, 1, 0, 0, 1);
      #3; n_run++;
      if (obs !== 5'b11000) begin n_fail++; $display("FAIL hold_a%0d: got %b want %b", i, obs, 5'b11000); end
      step();
    end
    drive(2, 4, 1, 3, 1, 0, 0, 0);
    #3; n_run++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL hold_release: got %b want %b", obs, 5'b11000); end
    step();
    exp = FWD ? 5'b00001 : 5'b11001;
    for (int i = 0; i < 3; i++) begin
      drive(2, 4, 1, 3, 1, 0, 0, (i < 2));
      #3; n_run++;
      if (obs !== exp) begin n_fail++; $display("FAIL hold_b%0d: got %b want %b", i, obs, exp); end
      step();
    end
    exp = FWD ? 5'b00000 : 5'b00010;
    #3; n_run++;
    if (obs !== exp) begin n_fail++; $display("FAIL hold_resolve: got %b want %b", obs, exp); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(1, 0, 0, 2, 1, 0, 0, 0);  // add r2
    step();
    drive(2, 1, 1, 5, 1, 0, 0, 0);  // sub r5,r2,r1
    step();
    #3;
    rst = 1'b0;
    #1; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL rst_mid_stall: got %b want %b", obs, 5'b00000); end
    step();
    #2; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL rst_held: got %b want %b", obs, 5'b00000); end
    rst = 1'b1;
    step();
    #3; n_run++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL rst_after_release: got %b want %b", obs, 5'b00000); end
    step();
  endtask

  task automatic test_random();
    logic [4:0] exp;
    bit         raw;
    drain();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      #3;
      raw = m_raw();
      exp = {raw && !br_taken, raw || br_taken, br_taken, 2'(m_cnt)};
      n_run++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: got %b want %b", i, obs, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_r0_unused_src2();
    test_branch_priority();
    test_pipe_hold();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
